// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - FSM state encoding (RUN/STALL/FLUSH/MEMWAIT)
//   - register address width, stall counter width, memory wait limit
//   - control bundle struct driven by the priority mux
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 4;
  localparam int STALL_CNT_W = 16;
  localparam int WAIT_LIMIT  = 255;
  localparam int WAIT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic freeze_front;
    logic freeze_back;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational source/destination compare.
// Ports:
//   id_src1, id_src2, id_valid, id_two_src : instruction in ID
//   exe_wb_en, exe_mem_r_en, exe_dest      : instruction in EXE
//   mem_wb_en, mem_dest                    : instruction in MEM
//   fwd_en                                 : forwarding unit active
//   hazard                                 : raw (unmasked) data hazard
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_valid,
  input  logic                  id_two_src,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  fwd_en,
  output logic                  hazard
);

  logic m_src1;
  logic m_src2;

  // With forwarding, only a load in EXE cannot be bypassed in time;
  // without it, any pending write in EXE or MEM must be waited out.
  always_comb begin
    m_src1 = 1'b0;
    m_src2 = 1'b0;
    if (fwd_en) begin
      m_src1 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src1);
      m_src2 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src2);
    end else begin
      m_src1 = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1));
      m_src2 = (exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2));
    end
    hazard = id_valid & (m_src1 | (id_two_src & m_src2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline freeze/flush controller.
// Ports:
//   clk, rst (async, active-low)
//   id_* / exe_* / mem_* / fwd_en : hazard compare inputs (see hazard_detect)
//   br_taken                      : branch resolved taken in EXE
//   mem_req, mem_ready            : MEM access pending / completion
//   freeze_front, freeze_back     : hold PC+IF/ID ; hold ID/EX, EX/MEM, MEM/WB
//   flush_if_id, flush_id_ex      : synchronous flush of IF/ID ; ID/EX
//   state, stall_cnt, mem_timeout : FSM state, front-freeze count, sticky error
// Memory handshake: a MEM access is outstanding while mem_req=1; it
// completes in the cycle mem_ready=1. mem_req=1 & mem_ready=0 is a wait cycle.
// Controls are combinational (act in the cycle the condition is present);
// the FSM records which condition won for observation and FLUSH masking.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_valid,
  input  logic                   id_two_src,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0]  exe_dest,
  input  logic                   mem_wb_en,
  input  logic [REG_ADDR_W-1:0]  mem_dest,
  input  logic                   fwd_en,
  input  logic                   br_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   freeze_front,
  output logic                   freeze_back,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_timeout
);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;

  logic  hazard_raw;
  logic  hazard;
  logic  mem_wait;
  ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_valid     (id_valid),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .fwd_en       (fwd_en),
    .hazard       (hazard_raw)
  );

  // The cycle after a flush, ID holds a squashed instruction: ignore it.
  assign hazard   = hazard_raw & (state_q != ST_FLUSH);
  assign mem_wait = mem_req & ~mem_ready;

  // Priority mux and next-state. A held branch is deferred by mem_wait
  // and fires in the cycle mem_ready rises. Controls are forced low while
  // rst is asserted so nothing downstream moves during reset.
  always_comb begin
    ctrl    = '0;
    state_d = ST_RUN;
    if (mem_wait) begin
      ctrl.freeze_front = 1'b1;
      ctrl.freeze_back  = 1'b1;
      state_d           = ST_MEMWAIT;
    end else if (br_taken) begin
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
      state_d           = ST_FLUSH;
    end else if (hazard) begin
      ctrl.freeze_front = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
      state_d           = ST_STALL;
    end
    if (!rst) begin
      ctrl = '0;
    end
  end

  // Counters: stall_cnt saturates; wait_cnt clears whenever the wait ends
  // and parks at the limit once the timeout has been flagged.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    if (ctrl.freeze_front && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (mem_wait) begin
      if (wait_cnt_q == WAIT_CNT_W'(WAIT_LIMIT)) begin
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign freeze_front = ctrl.freeze_front;
  assign freeze_back  = ctrl.freeze_back;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign state        = state_q;
  assign stall_cnt    = stall_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        fwd_en, br_taken, mem_req, mem_ready;
  logic        freeze_front, freeze_back, flush_if_id, flush_id_ex;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_stall = '0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_valid(id_valid), .id_two_src(id_two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .fwd_en(fwd_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_idle();
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    id_valid = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_wb_en = 1'b0; fwd_en = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // advance one clock and settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load_use();
    fwd_en = 1'b1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
    id_valid = 1'b1; id_src1 = 4'd3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    mem_req = 1'b1; br_taken = 1'b1;
    #12;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b0000) begin
      $display("FAIL reset_controls: got %b exp 0000", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      $display("FAIL reset_regs: state=%0d stall=%0d to=%b exp 0/0/0", state, stall_cnt, mem_timeout);
      n_fail++;
    end
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (state !== 2'd0) begin
      $display("FAIL reset_release_state: got %0d exp 0", state);
      n_fail++;
    end
  endtask

  task automatic test_load_use();
    set_idle();
    drive_load_use();
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b1001) begin
      $display("FAIL load_use_ctrl: got %b exp 1001", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    step();
    exp_stall = exp_stall + 16'd1;
    n_checks++;
    if (state !== 2'd1 || stall_cnt !== exp_stall) begin
      $display("FAIL load_use_state: state=%0d stall=%0d exp 1/%0d", state, stall_cnt, exp_stall);
      n_fail++;
    end
    id_src1 = 4'd4;
    #1;
    n_checks++;
    if (freeze_front !== 1'b0 || flush_id_ex !== 1'b0) begin
      $display("FAIL load_use_nomatch: ff=%b fidex=%b exp 0/0", freeze_front, flush_id_ex);
      n_fail++;
    end
    step();
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== exp_stall) begin
      $display("FAIL load_use_back_run: state=%0d stall=%0d exp 0/%0d", state, stall_cnt, exp_stall);
      n_fail++;
    end
  endtask

  task automatic test_mem_hazard();
    set_idle();
    mem_wb_en = 1'b1; mem_dest = 4'd5; id_valid = 1'b1; id_two_src = 1'b1;
    id_src1 = 4'd1; id_src2 = 4'd5;
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b1001) begin
      $display("FAIL mem_hazard_nofwd: got %b exp 1001", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    fwd_en = 1'b1;
    #1;
    n_checks++;
    if (freeze_front !== 1'b0 || flush_id_ex !== 1'b0) begin
      $display("FAIL mem_hazard_fwd: ff=%b fidex=%b exp 0/0", freeze_front, flush_id_ex);
      n_fail++;
    end
    fwd_en = 1'b0; id_two_src = 1'b0;
    #1;
    n_checks++;
    if (freeze_front !== 1'b0) begin
      $display("FAIL mem_hazard_one_src: ff=%b exp 0", freeze_front);
      n_fail++;
    end
    id_two_src = 1'b1; id_valid = 1'b0;
    #1;
    n_checks++;
    if (freeze_front !== 1'b0) begin
      $display("FAIL mem_hazard_invalid: ff=%b exp 0", freeze_front);
      n_fail++;
    end
    // EXE non-load write also stalls without forwarding
    set_idle();
    exe_wb_en = 1'b1; exe_dest = 4'd7; id_valid = 1'b1; id_src1 = 4'd7;
    #1;
    n_checks++;
    if (freeze_front !== 1'b1) begin
      $display("FAIL exe_hazard_nofwd: ff=%b exp 1", freeze_front);
      n_fail++;
    end
    set_idle();
    #1;
  endtask

  task automatic test_branch();
    set_idle();
    drive_load_use();
    br_taken = 1'b1;
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b0011) begin
      $display("FAIL branch_ctrl: got %b exp 0011", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    step();
    n_checks++;
    if (state !== 2'd2 || stall_cnt !== exp_stall) begin
      $display("FAIL branch_state: state=%0d stall=%0d exp 2/%0d", state, stall_cnt, exp_stall);
      n_fail++;
    end
    br_taken = 1'b0;
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b0000) begin
      $display("FAIL branch_mask: got %b exp 0000", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    step();
    n_checks++;
    if (state !== 2'd0 || freeze_front !== 1'b1) begin
      $display("FAIL branch_unmask: state=%0d ff=%b exp 0/1", state, freeze_front);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b1100) begin
        $display("FAIL mem_wait_ctrl[%0d]: got %b exp 1100", i, {freeze_front, freeze_back, flush_if_id, flush_id_ex});
        n_fail++;
      end
      step();
      exp_stall = exp_stall + 16'd1;
      n_checks++;
      if (state !== 2'd3) begin
        $display("FAIL mem_wait_state[%0d]: got %0d exp 3", i, state);
        n_fail++;
      end
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b0011) begin
      $display("FAIL mem_wait_release: got %b exp 0011", {freeze_front, freeze_back, flush_if_id, flush_id_ex});
      n_fail++;
    end
    step();
    n_checks++;
    if (state !== 2'd2 || stall_cnt !== exp_stall || mem_timeout !== 1'b0) begin
      $display("FAIL mem_wait_after: state=%0d stall=%0d to=%b exp 2/%0d/0", state, stall_cnt, mem_timeout, exp_stall);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_stall = exp_stall + 16'd1;
      if (i == 255) begin
        n_checks++;
        if (mem_timeout !== 1'b0) begin
          $display("FAIL timeout_early: got %b exp 0 after 255 cycles", mem_timeout);
          n_fail++;
        end
      end
      if (i == 256) begin
        n_checks++;
        if (mem_timeout !== 1'b1) begin
          $display("FAIL timeout_rise: got %b exp 1 after 256 cycles", mem_timeout);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (freeze_front !== 1'b1 || freeze_back !== 1'b1 || state !== 2'd3) begin
      $display("FAIL timeout_still_frozen: ff=%b fb=%b state=%0d exp 1/1/3", freeze_front, freeze_back, state);
      n_fail++;
    end
    mem_ready = 1'b1;
    step();
    set_idle();
    step();
    n_checks++;
    if (mem_timeout !== 1'b1 || stall_cnt !== exp_stall) begin
      $display("FAIL timeout_sticky: to=%b stall=%0d exp 1/%0d", mem_timeout, stall_cnt, exp_stall);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_memwait();
    set_idle();
    mem_req = 1'b1;
    step();
    step();
    n_checks++;
    if (state !== 2'd3) begin
      $display("FAIL rst_mid_pre: state=%0d exp 3", state);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({freeze_front, freeze_back, flush_if_id, flush_id_ex} !== 4'b0000 || state !== 2'd0
        || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      $display("FAIL rst_mid: ctrl=%b state=%0d stall=%0d to=%b exp 0000/0/0/0",
               {freeze_front, freeze_back, flush_if_id, flush_id_ex}, state, stall_cnt, mem_timeout);
      n_fail++;
    end
    exp_stall = '0;
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0) begin
      $display("FAIL rst_mid_release: state=%0d stall=%0d exp 0/0", state, stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_stall_saturate();
    set_idle();
    drive_load_use();
    for (int i = 1; i <= 65540; i++) begin
      step();
      if (i == 65535) begin
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
          $display("FAIL stall_reach_max: got %0h exp ffff", stall_cnt);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      $display("FAIL stall_saturate: got %0h exp ffff", stall_cnt);
      n_fail++;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_mem_hazard();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_memwait();
    test_stall_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
